// File: rtl/snn_layer_sequencer.sv
// Layer sequencer and shared-SRAM arbiter: launches enabled layer engines in
// index order and hands the whole bank set to exactly one engine at a time.
module snn_layer_sequencer #(
  parameter int NUM_STAGES = 3,
  parameter int NUM_BANKS  = 3,
  parameter int AW         = 12,
  parameter int DW         = 16,
  parameter int TIMEOUT    = 65536,
  parameter int SW         = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 run_start,
  input  logic [NUM_STAGES-1:0]                stage_en,
  input  logic                                 abort,
  output logic [NUM_STAGES-1:0]                stage_start,
  input  logic [NUM_STAGES-1:0]                stage_done,
  input  logic [NUM_STAGES*NUM_BANKS*AW-1:0]   eng_addr,
  input  logic [NUM_STAGES*NUM_BANKS-1:0]      eng_we,
  input  logic [NUM_STAGES*NUM_BANKS*DW-1:0]   eng_wdata,
  output logic [NUM_BANKS*AW-1:0]              bank_addr,
  output logic [NUM_BANKS-1:0]                 bank_we,
  output logic [NUM_BANKS*DW-1:0]              bank_wdata,
  output logic                                 busy,
  output logic [SW-1:0]                        active_stage,
  output logic                                 grant_valid,
  output logic                                 done,
  output logic                                 error,
  output logic [SW-1:0]                        err_stage
);

  localparam int WDW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [WDW-1:0] WD_LAST = WDW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam bit WD_EN = (TIMEOUT != 0);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT,
    S_GAP,
    S_FINISH
  } state_t;

  state_t                state_q;
  logic [NUM_STAGES-1:0] mask_q;
  logic [SW-1:0]         idx_q;
  logic [WDW-1:0]        wd_q;
  logic                  busy_q;
  logic                  grant_q;
  logic [NUM_STAGES-1:0] start_q;
  logic                  done_q;
  logic                  err_q;
  logic [SW-1:0]         err_stage_q;

  logic [SW:0]           first_d;
  logic [SW:0]           next_d;

  // Returns {found, index} of the lowest set bit of m at or above position lo.
  function automatic logic [SW:0] find_from(input logic [NUM_STAGES-1:0] m, input int lo);
    logic [SW:0] r;
    r = '0;
    for (int i = NUM_STAGES - 1; i >= 0; i--) begin
      if (i >= lo && m[i]) r = {1'b1, SW'(i)};
    end
    return r;
  endfunction

  always_comb begin
    first_d = find_from(stage_en, 0);
    next_d  = find_from(mask_q, int'(idx_q) + 1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      mask_q      <= '0;
      idx_q       <= '0;
      wd_q        <= '0;
      busy_q      <= 1'b0;
      grant_q     <= 1'b0;
      start_q     <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      err_stage_q <= '0;
    end else begin
      start_q <= '0;
      done_q  <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (run_start) begin
            err_q <= 1'b0;
            if (stage_en != '0) begin
              mask_q      <= stage_en;
              err_stage_q <= '0;
              idx_q       <= first_d[SW-1:0];
              start_q     <= NUM_STAGES'(1) << first_d[SW-1:0];
              grant_q     <= 1'b1;
              busy_q      <= 1'b1;
              state_q     <= S_LAUNCH;
            end else begin
              done_q <= 1'b1;
            end
          end
        end
        S_LAUNCH: begin
          if (abort) begin
            grant_q <= 1'b0;
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end else begin
            wd_q    <= '0;
            state_q <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (abort) begin
            grant_q <= 1'b0;
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end else if (stage_done[idx_q]) begin
            // Grant drops for one cycle either way so no two owners ever touch the banks back to back.
            grant_q <= 1'b0;
            if (next_d[SW]) begin
              state_q <= S_GAP;
            end else begin
              done_q  <= 1'b1;
              state_q <= S_FINISH;
            end
          end else if (WD_EN && wd_q == WD_LAST) begin
            err_q       <= 1'b1;
            err_stage_q <= idx_q;
            grant_q     <= 1'b0;
            busy_q      <= 1'b0;
            state_q     <= S_IDLE;
          end else begin
            wd_q <= wd_q + 1'b1;
          end
        end
        S_GAP: begin
          if (abort) begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end else begin
            idx_q   <= next_d[SW-1:0];
            start_q <= NUM_STAGES'(1) << next_d[SW-1:0];
            grant_q <= 1'b1;
            state_q <= S_LAUNCH;
          end
        end
        S_FINISH: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          grant_q <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  // Per-stage fields are contiguous, so a stage's whole bank set is one slice.
  always_comb begin
    bank_addr  = '0;
    bank_we    = '0;
    bank_wdata = '0;
    if (grant_q) begin
      for (int s = 0; s < NUM_STAGES; s++) begin
        if (idx_q == SW'(s)) begin
          bank_addr  = eng_addr[s*NUM_BANKS*AW +: NUM_BANKS*AW];
          bank_we    = eng_we[s*NUM_BANKS +: NUM_BANKS];
          bank_wdata = eng_wdata[s*NUM_BANKS*DW +: NUM_BANKS*DW];
        end
      end
    end
  end

  assign stage_start  = start_q;
  assign busy         = busy_q;
  assign active_stage = idx_q;
  assign grant_valid  = grant_q;
  assign done         = done_q;
  assign error        = err_q;
  assign err_stage    = err_stage_q;

endmodule

// File: tb/tb_snn_layer_sequencer.sv
// Directed bench for snn_layer_sequencer: default-timeout instance for sequencing,
// muxing, abort and reset; TIMEOUT=8 instance for the watchdog.
module tb_snn_layer_sequencer;

  localparam int NS = 3;
  localparam int NB = 3;
  localparam int AW = 12;
  localparam int DW = 16;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic [NS*NB*AW-1:0] eng_addr;
  logic [NS*NB-1:0]    eng_we;
  logic [NS*NB*DW-1:0] eng_wdata;

  logic          run_start = 1'b0, abort = 1'b0;
  logic [NS-1:0] stage_en = '0, stage_done = '0;
  logic [NS-1:0] stage_start;
  logic [NB*AW-1:0] bank_addr;
  logic [NB-1:0]    bank_we;
  logic [NB*DW-1:0] bank_wdata;
  logic busy, grant_valid, done, error;
  logic [1:0] active_stage, err_stage;

  logic          run_start_b = 1'b0, abort_b = 1'b0;
  logic [NS-1:0] stage_en_b = '0, stage_done_b = '0;
  logic [NS-1:0] stage_start_b;
  logic [NB*AW-1:0] bank_addr_b;
  logic [NB-1:0]    bank_we_b;
  logic [NB*DW-1:0] bank_wdata_b;
  logic busy_b, grant_valid_b, done_b, error_b;
  logic [1:0] active_stage_b, err_stage_b;

  int errors = 0;
  int checks = 0;

  snn_layer_sequencer #(.NUM_STAGES(NS), .NUM_BANKS(NB), .AW(AW), .DW(DW)) dut (
    .clk(clk), .reset(reset), .run_start(run_start), .stage_en(stage_en), .abort(abort),
    .stage_start(stage_start), .stage_done(stage_done), .eng_addr(eng_addr), .eng_we(eng_we),
    .eng_wdata(eng_wdata), .bank_addr(bank_addr), .bank_we(bank_we), .bank_wdata(bank_wdata),
    .busy(busy), .active_stage(active_stage), .grant_valid(grant_valid), .done(done),
    .error(error), .err_stage(err_stage)
  );

  snn_layer_sequencer #(.NUM_STAGES(NS), .NUM_BANKS(NB), .AW(AW), .DW(DW), .TIMEOUT(8)) dut_wd (
    .clk(clk), .reset(reset), .run_start(run_start_b), .stage_en(stage_en_b), .abort(abort_b),
    .stage_start(stage_start_b), .stage_done(stage_done_b), .eng_addr(eng_addr), .eng_we(eng_we),
    .eng_wdata(eng_wdata), .bank_addr(bank_addr_b), .bank_we(bank_we_b), .bank_wdata(bank_wdata_b),
    .busy(busy_b), .active_stage(active_stage_b), .grant_valid(grant_valid_b), .done(done_b),
    .error(error_b), .err_stage(err_stage_b)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #3;
    checks++;
    if ({stage_start, bank_addr, bank_we, bank_wdata, busy, active_stage, grant_valid, done, error, err_stage} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got start=%b we=%b busy=%b grant=%b done=%b err=%b want all zero",
               stage_start, bank_we, busy, grant_valid, done, error);
    end
    checks++;
    if ({stage_start_b, bank_we_b, busy_b, grant_valid_b, done_b, error_b} !== '0) begin
      errors++;
      $display("FAIL reset_outputs_wd: got start=%b we=%b busy=%b grant=%b want all zero",
               stage_start_b, bank_we_b, busy_b, grant_valid_b);
    end
    @(negedge clk);
    reset = 1'b1;
    tick();
  endtask

  // Runs one masked sequence; each engine completes 10 cycles after its start.
  task automatic run_seq(input logic [2:0] mask, input string name);
    bit first = 1'b1;
    stage_en = mask;
    run_start = 1'b1;
    tick();
    run_start = 1'b0;
    stage_en = 3'b000;
    for (int s = 0; s < NS; s++) begin
      if (mask[s]) begin
        if (!first) tick();
        first = 1'b0;
        checks++;
        if (stage_start !== 3'(1 << s) || active_stage !== 2'(s) || grant_valid !== 1'b1 || busy !== 1'b1) begin
          errors++;
          $display("FAIL %s_start%0d: got start=%b active=%0d grant=%b want start=%b active=%0d grant=1",
                   name, s, stage_start, active_stage, grant_valid, 3'(1 << s), s);
        end
        for (int k = 0; k < 10; k++) begin
          tick();
          checks++;
          if (stage_start !== 3'b000 || grant_valid !== 1'b1 || active_stage !== 2'(s) || bank_we !== 3'b111) begin
            errors++;
            $display("FAIL %s_wait%0d: got start=%b grant=%b active=%0d we=%b want 000/1/%0d/111",
                     name, s, stage_start, grant_valid, active_stage, bank_we, s);
          end
        end
        stage_done[s] = 1'b1;
        tick();
        stage_done[s] = 1'b0;
        checks++;
        if ((mask >> (s + 1)) != 3'b000) begin
          if (grant_valid !== 1'b0 || bank_we !== 3'b000 || busy !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL %s_gap%0d: got grant=%b we=%b busy=%b done=%b want 0/000/1/0",
                     name, s, grant_valid, bank_we, busy, done);
          end
        end else begin
          if (done !== 1'b1 || grant_valid !== 1'b0 || bank_we !== 3'b000) begin
            errors++;
            $display("FAIL %s_done: got done=%b grant=%b we=%b want 1/0/000", name, done, grant_valid, bank_we);
          end
        end
      end
    end
    tick();
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || stage_start !== 3'b000) begin
      errors++;
      $display("FAIL %s_idle: got done=%b busy=%b start=%b want 0/0/000", name, done, busy, stage_start);
    end
  endtask

  task automatic test_full_run();
    run_seq(3'b111, "full");
  endtask

  task automatic test_mask_skip();
    run_seq(3'b101, "skip");
  endtask

  task automatic test_mux_isolation();
    stage_en = 3'b010;
    run_start = 1'b1;
    tick();
    run_start = 1'b0;
    checks++;
    if (bank_addr !== {12'd102, 12'd101, 12'd100} || bank_wdata !== {3{16'hA001}} || bank_we !== 3'b111) begin
      errors++;
      $display("FAIL mux_stage1: got addr=%h wdata=%h we=%b want %h %h 111",
               bank_addr, bank_wdata, bank_we, {12'd102, 12'd101, 12'd100}, {3{16'hA001}});
    end
    tick();
    stage_done = 3'b010;
    tick();
    stage_done = 3'b000;
    checks++;
    if (bank_addr !== '0 || bank_wdata !== '0 || bank_we !== 3'b000 || grant_valid !== 1'b0 || done !== 1'b1) begin
      errors++;
      $display("FAIL mux_nogrant: got addr=%h wdata=%h we=%b grant=%b done=%b want zeros, done=1",
               bank_addr, bank_wdata, bank_we, grant_valid, done);
    end
    tick();
  endtask

  task automatic test_watchdog();
    int saw_done = 0;
    stage_en_b = 3'b011;
    run_start_b = 1'b1;
    tick();
    run_start_b = 1'b0;
    tick();
    stage_done_b = 3'b001;
    tick();
    stage_done_b = 3'b000;
    tick();
    checks++;
    if (stage_start_b !== 3'b010) begin
      errors++;
      $display("FAIL wd_start1: got start=%b want 010", stage_start_b);
    end
    for (int k = 0; k < 7; k++) begin
      tick();
      if (done_b) saw_done++;
    end
    checks++;
    if (error_b !== 1'b0 || busy_b !== 1'b1) begin
      errors++;
      $display("FAIL wd_early: got error=%b busy=%b want 0/1", error_b, busy_b);
    end
    tick();
    if (done_b) saw_done++;
    tick();
    if (done_b) saw_done++;
    checks++;
    if (error_b !== 1'b1 || err_stage_b !== 2'd1 || busy_b !== 1'b0 || grant_valid_b !== 1'b0) begin
      errors++;
      $display("FAIL wd_timeout: got error=%b err_stage=%0d busy=%b grant=%b want 1/1/0/0",
               error_b, err_stage_b, busy_b, grant_valid_b);
    end
    for (int k = 0; k < 3; k++) begin
      tick();
      if (done_b) saw_done++;
    end
    checks++;
    if (saw_done !== 0 || error_b !== 1'b1) begin
      errors++;
      $display("FAIL wd_sticky: got done_pulses=%0d error=%b want 0/1", saw_done, error_b);
    end
    stage_en_b = 3'b001;
    run_start_b = 1'b1;
    tick();
    run_start_b = 1'b0;
    checks++;
    if (error_b !== 1'b0 || err_stage_b !== 2'd0 || stage_start_b !== 3'b001) begin
      errors++;
      $display("FAIL wd_clear: got error=%b err_stage=%0d start=%b want 0/0/001", error_b, err_stage_b, stage_start_b);
    end
    tick();
    stage_done_b = 3'b001;
    tick();
    stage_done_b = 3'b000;
    tick();
  endtask

  task automatic test_abort_stray();
    stage_en = 3'b101;
    run_start = 1'b1;
    tick();
    run_start = 1'b0;
    tick();
    stage_done = 3'b100;
    tick();
    stage_done = 3'b000;
    checks++;
    if (grant_valid !== 1'b1 || active_stage !== 2'd0 || busy !== 1'b1 || stage_start !== 3'b000) begin
      errors++;
      $display("FAIL stray_done: got grant=%b active=%0d busy=%b start=%b want 1/0/1/000",
               grant_valid, active_stage, busy, stage_start);
    end
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    checks++;
    if (busy !== 1'b0 || grant_valid !== 1'b0 || done !== 1'b0 || error !== 1'b0 || bank_we !== 3'b000) begin
      errors++;
      $display("FAIL abort_wait: got busy=%b grant=%b done=%b error=%b we=%b want 0/0/0/0/000",
               busy, grant_valid, done, error, bank_we);
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || stage_start !== 3'b000) begin
      errors++;
      $display("FAIL abort_idle: got busy=%b done=%b start=%b want 0/0/000", busy, done, stage_start);
    end
  endtask

  task automatic test_empty_and_reset();
    stage_en = 3'b000;
    run_start = 1'b1;
    tick();
    run_start = 1'b0;
    checks++;
    if (done !== 1'b1 || stage_start !== 3'b000 || busy !== 1'b0) begin
      errors++;
      $display("FAIL empty_mask: got done=%b start=%b busy=%b want 1/000/0", done, stage_start, busy);
    end
    tick();
    stage_en = 3'b001;
    run_start = 1'b1;
    tick();
    run_start = 1'b0;
    tick();
    checks++;
    if (bank_we !== 3'b111 || grant_valid !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset: got we=%b grant=%b busy=%b want 111/1/1", bank_we, grant_valid, busy);
    end
    #2 reset = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || grant_valid !== 1'b0 || bank_we !== 3'b000) begin
      errors++;
      $display("FAIL async_reset: got busy=%b grant=%b we=%b want 0/0/000", busy, grant_valid, bank_we);
    end
    @(negedge clk);
    reset = 1'b1;
    tick();
  endtask

  initial begin
    eng_we = '1;
    for (int s = 0; s < NS; s++) begin
      for (int b = 0; b < NB; b++) begin
        eng_addr[(s*NB+b)*AW +: AW]  = AW'(s * 100 + b);
        eng_wdata[(s*NB+b)*DW +: DW] = 16'hA000 + DW'(s);
      end
    end
    test_reset();
    test_full_run();
    test_mask_skip();
    test_mux_isolation();
    test_watchdog();
    test_abort_stray();
    test_empty_and_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
